// File: rtl/sar_adc_logic.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sar_adc_logic : successive-approximation controller for the SAR ADC core |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module sar_adc_logic #(
  parameter int NBITS         = 12,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample_o,
  output logic             cmp_clk_o,
  output logic [NBITS-1:0] dac_o,
  output logic             busy,
  output logic [NBITS-1:0] result,
  output logic             valid,
  output logic             overrun
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(NBITS);

  localparam logic [CW-1:0]    C_SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0]    C_SETTLE_LOAD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [IW-1:0]    C_IDX_MSB     = IW'(NBITS - 1);
  localparam logic [NBITS-1:0] C_DAC_MSB     = {1'b1, {(NBITS-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_SETTLE = 3'd2,
    S_STROBE = 3'd3,
    S_DECIDE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_idx;
  logic [NBITS-1:0] r_dac;
  logic [NBITS-1:0] r_result;
  logic             r_overrun;
  logic             w_cnt_zero;
  logic             w_idx_zero;
  logic [NBITS-1:0] w_dac_dec;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_idx_zero = (r_idx == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    sample_o  = 1'b0;
    cmp_clk_o = 1'b0;
    busy      = 1'b0;
    valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_n = S_SAMPLE;
      end
      S_SAMPLE: begin
        sample_o = 1'b1;
        busy     = 1'b1;
        if (w_cnt_zero) begin
          if (SETTLE_CYCLES > 0) w_state_n = S_SETTLE;
          else                   w_state_n = S_STROBE;
        end
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (w_cnt_zero) w_state_n = S_STROBE;
      end
      S_STROBE: begin
        busy      = 1'b1;
        cmp_clk_o = 1'b1;
        w_state_n = S_DECIDE;
      end
      S_DECIDE: begin
        busy = 1'b1;
        if (w_idx_zero)             w_state_n = S_DONE;
        else if (SETTLE_CYCLES > 0) w_state_n = S_SETTLE;
        else                        w_state_n = S_STROBE;
      end
      S_DONE: begin
        valid     = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Resolve the current trial bit and arm the next lower one.
  always_comb begin
    w_dac_dec        = r_dac;
    w_dac_dec[r_idx] = cmp_in;
    if (!w_idx_zero) w_dac_dec[r_idx - 1'b1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_dac     <= '0;
      r_result  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (start && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_dac <= '0;
          if (start) begin
            r_overrun <= 1'b0;
            r_cnt     <= C_SAMPLE_LOAD;
          end
        end
        S_SAMPLE: begin
          if (w_cnt_zero) begin
            r_idx <= C_IDX_MSB;
            r_dac <= C_DAC_MSB;
            r_cnt <= C_SETTLE_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SETTLE: begin
          if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
        end
        S_DECIDE: begin
          r_dac <= w_dac_dec;
          if (w_idx_zero) begin
            r_result <= w_dac_dec;
          end else begin
            r_idx <= r_idx - 1'b1;
            r_cnt <= C_SETTLE_LOAD;
          end
        end
        // Final code stays visible through DONE, then IDLE shows zero.
        S_DONE:  r_dac <= '0;
        default: ;
      endcase
    end
  end

  assign dac_o   = r_dac;
  assign result  = r_result;
  assign overrun = r_overrun;

endmodule
`default_nettype wire
